// File: rtl/troco_pkg.sv
// rtl/troco_pkg.sv - shared states, coin encoding and coin values for the change dispenser
package troco_pkg;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        SELECIONA = 3'd1,
        PULSO     = 3'd2,
        INTERVALO = 3'd3,
        FIM       = 3'd4
    } estado_t;

    typedef enum logic [1:0] {
        MOEDA_REAL1  = 2'd0,
        MOEDA_CENT50 = 2'd1,
        MOEDA_CENT25 = 2'd2
    } moeda_t;

    localparam int VALOR_REAL1  = 4;
    localparam int VALOR_CENT50 = 2;
    localparam int VALOR_CENT25 = 1;

    function automatic int valor_moeda(moeda_t m);
        case (m)
            MOEDA_REAL1:  return VALOR_REAL1;
            MOEDA_CENT50: return VALOR_CENT50;
            default:      return VALOR_CENT25;
        endcase
    endfunction

endpackage

// File: rtl/seletor_moeda.sv
// rtl/seletor_moeda.sv - combinational largest-coin picker; stock-aware when TROCO_ESTOQUE_EN is defined
import troco_pkg::*;

module seletor_moeda #(
    parameter int W_CRED = 4
) (
    input  logic [W_CRED-1:0] restante,
`ifdef TROCO_ESTOQUE_EN
    input  logic [2:0]        tem_estoque,
`endif
    output moeda_t            moeda,
    output logic              nenhuma
);

    always_comb begin
        moeda   = MOEDA_CENT25;
        nenhuma = 1'b0;
`ifdef TROCO_ESTOQUE_EN
        // bit order of tem_estoque follows moeda_t: real1, cent50, cent25
        if (restante >= W_CRED'(VALOR_REAL1) && tem_estoque[0]) begin
            moeda = MOEDA_REAL1;
        end else if (restante >= W_CRED'(VALOR_CENT50) && tem_estoque[1]) begin
            moeda = MOEDA_CENT50;
        end else if (restante != '0 && tem_estoque[2]) begin
            moeda = MOEDA_CENT25;
        end else begin
            nenhuma = 1'b1;
        end
`else
        if (restante >= W_CRED'(VALOR_REAL1)) begin
            moeda = MOEDA_REAL1;
        end else if (restante >= W_CRED'(VALOR_CENT50)) begin
            moeda = MOEDA_CENT50;
        end else begin
            nenhuma = (restante == '0);
        end
`endif
    end

endmodule

// File: rtl/dispensador_troco.sv
// rtl/dispensador_troco.sv - change dispenser FSM with pulse/gap timer; TROCO_ESTOQUE_EN adds per-coin stock counters
import troco_pkg::*;

module dispensador_troco #(
    parameter int W_CRED       = 4,
    parameter int PULSE_CYC    = 4,
    parameter int GAP_CYC      = 2,
    parameter int ESTOQUE_INIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iniciar,
    input  logic [W_CRED-1:0] valor,
    input  logic              repor,
    output logic              ocupado,
    output logic              concluido,
    output logic              erro,
    output logic              ejetar_real1,
    output logic              ejetar_cent50,
    output logic              ejetar_cent25,
    output logic [W_CRED-1:0] restante
);

    localparam int TW = 8;

    estado_t           estado_q;
    moeda_t            moeda_q;
    moeda_t            moeda_sel;
    logic              nenhuma;
    logic [TW-1:0]     tempo_q;
    logic [W_CRED-1:0] resto_q;
    logic              ocupado_q, concluido_q;
    logic              real1_q, cent50_q, cent25_q;
    logic [W_CRED-1:0] restante_q;

`ifdef TROCO_ESTOQUE_EN
    localparam logic [3:0] ESTOQUE_CHEIO = 4'(ESTOQUE_INIT);

    logic [2:0][3:0] estoque_q;
    logic [2:0]      tem_estoque;
    logic            falha_q;
    logic            erro_q;

    for (genvar g = 0; g < 3; g++) begin : g_tem
        assign tem_estoque[g] = (estoque_q[g] != 4'd0);
    end

    seletor_moeda #(.W_CRED(W_CRED)) u_seletor (
        .restante    (resto_q),
        .tem_estoque (tem_estoque),
        .moeda       (moeda_sel),
        .nenhuma     (nenhuma)
    );

    assign erro = erro_q;
`else
    localparam int estoque_init_unused = ESTOQUE_INIT;
    logic repor_unused;
    assign repor_unused = repor;

    seletor_moeda #(.W_CRED(W_CRED)) u_seletor (
        .restante (resto_q),
        .moeda    (moeda_sel),
        .nenhuma  (nenhuma)
    );

    assign erro = 1'b0;
`endif

    // Outputs are registered from the current state, so they trail the FSM by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= OCIOSO;
            moeda_q     <= MOEDA_CENT25;
            tempo_q     <= '0;
            resto_q     <= '0;
            ocupado_q   <= 1'b0;
            concluido_q <= 1'b0;
            real1_q     <= 1'b0;
            cent50_q    <= 1'b0;
            cent25_q    <= 1'b0;
            restante_q  <= '0;
`ifdef TROCO_ESTOQUE_EN
            estoque_q   <= {3{ESTOQUE_CHEIO}};
            falha_q     <= 1'b0;
            erro_q      <= 1'b0;
`endif
        end else begin
            ocupado_q   <= (estado_q != OCIOSO);
            concluido_q <= (estado_q == FIM);
            real1_q     <= (estado_q == PULSO) && (moeda_q == MOEDA_REAL1);
            cent50_q    <= (estado_q == PULSO) && (moeda_q == MOEDA_CENT50);
            cent25_q    <= (estado_q == PULSO) && (moeda_q == MOEDA_CENT25);
            restante_q  <= resto_q;
`ifdef TROCO_ESTOQUE_EN
            erro_q      <= (estado_q == FIM) && falha_q;
`endif
            case (estado_q)
                OCIOSO: begin
                    if (iniciar) begin
                        resto_q  <= valor;
                        estado_q <= (valor == '0) ? FIM : SELECIONA;
`ifdef TROCO_ESTOQUE_EN
                        falha_q  <= 1'b0;
`endif
                    end
`ifdef TROCO_ESTOQUE_EN
                    if (repor) begin
                        estoque_q <= {3{ESTOQUE_CHEIO}};
                    end
`endif
                end
                SELECIONA: begin
                    if (nenhuma) begin
                        estado_q <= FIM;
`ifdef TROCO_ESTOQUE_EN
                        falha_q  <= 1'b1;
`endif
                    end else begin
                        moeda_q  <= moeda_sel;
                        tempo_q  <= '0;
                        estado_q <= PULSO;
                    end
                end
                PULSO: begin
                    if (tempo_q == TW'(PULSE_CYC - 1)) begin
                        resto_q  <= resto_q - W_CRED'(valor_moeda(moeda_q));
                        tempo_q  <= '0;
                        estado_q <= INTERVALO;
`ifdef TROCO_ESTOQUE_EN
                        case (moeda_q)
                            MOEDA_REAL1:  estoque_q[0] <= estoque_q[0] - 4'd1;
                            MOEDA_CENT50: estoque_q[1] <= estoque_q[1] - 4'd1;
                            default:      estoque_q[2] <= estoque_q[2] - 4'd1;
                        endcase
`endif
                    end else begin
                        tempo_q <= tempo_q + TW'(1);
                    end
                end
                INTERVALO: begin
                    if (tempo_q == TW'(GAP_CYC - 1)) begin
                        estado_q <= (resto_q == '0) ? FIM : SELECIONA;
                    end else begin
                        tempo_q <= tempo_q + TW'(1);
                    end
                end
                FIM:     estado_q <= OCIOSO;
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign ocupado       = ocupado_q;
    assign concluido     = concluido_q;
    assign ejetar_real1  = real1_q;
    assign ejetar_cent50 = cent50_q;
    assign ejetar_cent25 = cent25_q;
    assign restante      = restante_q;

endmodule

// File: tb/tb_dispensador_troco.sv
// tb/tb_dispensador_troco.sv - randomized self-checking bench for dispensador_troco against a coin-list timeline model
module tb_dispensador_troco;

    localparam int P = 4;
    localparam int G = 2;
    localparam int C = 1 + P + G;
`ifdef TROCO_ESTOQUE_EN
    localparam bit EST_EN   = 1'b1;
    localparam int EST_INIT = 1;
`else
    localparam bit EST_EN   = 1'b0;
    localparam int EST_INIT = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] valor = 4'd0;
    logic       repor = 1'b0;
    logic       ocupado, concluido, erro;
    logic       ejetar_real1, ejetar_cent50, ejetar_cent25;
    logic [3:0] restante;
    logic [9:0] obs;

    int checks = 0;
    int errors = 0;

    // Reference model: a coin list derived from the greedy rule, plus stock and the last remainder.
    int coins[$];
    int den[3] = '{4, 2, 1};
    int stock[3];
    int m_valor, m_prev, m_last;
    bit m_err;

    dispensador_troco #(
        .W_CRED(4), .PULSE_CYC(P), .GAP_CYC(G), .ESTOQUE_INIT(EST_INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .valor(valor), .repor(repor),
        .ocupado(ocupado), .concluido(concluido), .erro(erro),
        .ejetar_real1(ejetar_real1), .ejetar_cent50(ejetar_cent50),
        .ejetar_cent25(ejetar_cent25), .restante(restante)
    );

    always #5 clk = ~clk;

    assign obs = {ocupado, concluido, erro, ejetar_real1, ejetar_cent50, ejetar_cent25, restante};

    task automatic model_reset();
        m_last = 0;
        for (int j = 0; j < 3; j++) stock[j] = EST_INIT;
    endtask

    task automatic plan(input int v, input bit rep);
        int  rest;
        bit  ok;
        if (rep && EST_EN) for (int j = 0; j < 3; j++) stock[j] = EST_INIT;
        m_prev  = m_last;
        m_valor = v;
        m_err   = 1'b0;
        coins.delete();
        rest = v;
        while (rest > 0 && !m_err) begin
            ok = 1'b0;
            for (int j = 0; j < 3; j++) begin
                if (!ok && den[j] <= rest && (!EST_EN || stock[j] > 0)) begin
                    coins.push_back(den[j]);
                    if (EST_EN) stock[j]--;
                    rest -= den[j];
                    ok = 1'b1;
                end
            end
            if (!ok) m_err = 1'b1;
        end
        m_last = rest;
    endtask

    function automatic int op_len();
        return 1 + coins.size() * C + (m_err ? 1 : 0);
    endfunction

    // Expected outputs in the cycle after edge E<k>, E0 being the edge that samples iniciar.
    function automatic logic [9:0] expect_at(int k);
        int   tc, rest, s;
        logic oc, co, er, r1, c5, c2;
        tc = op_len();
        oc = (k >= 1 && k <= tc);
        co = (k == tc);
        er = co && m_err;
        r1 = 1'b0; c5 = 1'b0; c2 = 1'b0;
        rest = (k < 1) ? m_prev : m_valor;
        for (int i = 0; i < coins.size(); i++) begin
            s = i * C;
            if (k >= 2 + s && k <= 1 + s + P) begin
                if (coins[i] == 4) r1 = 1'b1;
                else if (coins[i] == 2) c5 = 1'b1;
                else c2 = 1'b1;
            end
            if (k >= 2 + s + P) rest -= coins[i];
        end
        return {oc, co, er, r1, c5, c2, 4'(rest)};
    endfunction

    task automatic start_op(input int v, input bit rep);
        plan(v, rep);
        iniciar = 1'b1;
        valor   = 4'(v);
        repor   = rep;
        @(posedge clk);
        #1;
        iniciar = 1'b0;
        repor   = 1'b0;
        valor   = 4'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 10'd0) begin
            errors++;
            $display("FAIL reset_held got=%b exp=%b", obs, 10'd0);
        end
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== 10'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", k, obs, 10'd0);
            end
        end
    endtask

    task automatic test_valor(input int v, input string nome);
        logic [9:0] exp;
        start_op(v, 1'b0);
        for (int k = 1; k <= op_len() + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp = expect_at(k);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s k=%0d got=%b exp=%b", nome, k, obs, exp);
            end
        end
    endtask

    task automatic test_ignore_mid_run();
        logic [9:0] exp;
        start_op(15, 1'b0);
        for (int k = 1; k <= op_len() + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp = expect_at(k);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL valor15_ignore k=%0d got=%b exp=%b", k, obs, exp);
            end
            if (k == 10) begin
                iniciar = 1'b1;
                valor   = 4'd4;
                repor   = 1'b1;
            end else if (k == 11) begin
                iniciar = 1'b0;
                repor   = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        for (int it = 0; it < 8; it++) begin
            start_op(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            for (int k = 1; k <= op_len() + 2; k++) begin
                @(posedge clk);
                @(negedge clk);
                exp = expect_at(k);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL random it=%0d valor=%0d k=%0d got=%b exp=%b", it, m_valor, k, obs, exp);
                end
            end
        end
    endtask

    task automatic test_estoque();
        logic [9:0] exp;
        start_op(9, 1'b1);
        for (int k = 1; k <= op_len() + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp = expect_at(k);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL estoque_9 k=%0d got=%b exp=%b", k, obs, exp);
            end
        end
        repor = 1'b1;
        if (EST_EN) for (int j = 0; j < 3; j++) stock[j] = EST_INIT;
        @(posedge clk);
        #1;
        repor = 1'b0;
        start_op(2, 1'b0);
        for (int k = 1; k <= op_len() + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp = expect_at(k);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL estoque_repor k=%0d got=%b exp=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp;
        start_op(2, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp = expect_at(k);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid_pre k=%0d got=%b exp=%b", k, obs, exp);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ejetar_cent50, ocupado, restante} !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid_async got=%b exp=%b", {ejetar_cent50, ocupado, restante}, 6'd0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== 10'd0) begin
                errors++;
                $display("FAIL reset_mid_hold cyc=%0d got=%b exp=%b", k, obs, 10'd0);
            end
        end
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== 10'd0) begin
                errors++;
                $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", k, obs, 10'd0);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_valor(7, "valor7");
        test_valor(0, "valor0");
        test_ignore_mid_run();
        test_estoque();
        test_back_to_back();
        test_reset_mid();
        test_valor(13, "after_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
